// File: rtl/mem_responder_if.sv
// Request/response bus between the core's memory stage and a memory target.
// The master drives requests and the slave (target) returns completions and status.
interface mem_responder_if;
    logic        request_enable;
    logic        mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        response_enable;
    logic [31:0] data;
    logic        busy;
    logic        err_range;
    logic        err_overflow;

    modport master (
        output request_enable, mode, addr, wdata, wstrb,
        input  response_enable, data, busy, err_range, err_overflow
    );

    modport slave (
        input  request_enable, mode, addr, wdata, wstrb,
        output response_enable, data, busy, err_range, err_overflow
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised on-chip RAM behind the memory request bus. It answers each request after a fixed latency,
// holds one request in service, and buffers one more request.
module mem_responder #(
    parameter int          DEPTH_LOG2 = 14,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rstn,
    mem_responder_if.slave  mem
);
    localparam logic MEMREQ_READ  = 1'b0;
    localparam logic MEMREQ_WRITE = 1'b1;
    localparam int   DEPTH        = 1 << DEPTH_LOG2;
    localparam logic [3:0] RELOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESPOND} state_e;

    typedef struct packed {
        logic        mode;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    // With a latency of one, the cycle after acceptance is already the response cycle.
    localparam state_e START = (LATENCY == 1) ? S_RESPOND : S_WAIT;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        act_q, act_d;
    req_t        pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        ovf_q, ovf_d;
    logic [31:0] data_q, data_d;
    req_t        in_req;
    logic        resp;
    logic        we;

    logic [31:0] ram_q [DEPTH];

    logic [31:0]           off;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;

    // The range test uses the full 32-bit offset, so addresses below the base do not wrap into the RAM.
    assign off      = act_q.addr - BASE_ADDR;
    assign in_range = (act_q.addr >= BASE_ADDR) && ((off >> 2) < (32'd1 << DEPTH_LOG2));
    assign idx      = off[DEPTH_LOG2+1:2];

    assign in_req = '{mode: mem.mode, addr: mem.addr, wdata: mem.wdata, wstrb: mem.wstrb};

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        act_d      = act_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovf_d      = ovf_q;
        data_d     = data_q;
        resp       = 1'b0;
        we         = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem.request_enable) begin
                    act_d   = in_req;
                    cnt_d   = RELOAD;
                    state_d = START;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) state_d = S_RESPOND;
                if (mem.request_enable) begin
                    if (pend_vld_q) begin
                        ovf_d = 1'b1;
                    end else begin
                        pend_d     = in_req;
                        pend_vld_d = 1'b1;
                    end
                end
            end
            S_RESPOND: begin
                resp   = 1'b1;
                we     = (act_q.mode == MEMREQ_WRITE) && in_range;
                data_d = ((act_q.mode == MEMREQ_READ) && in_range) ? ram_q[idx] : 32'd0;
                if (pend_vld_q) begin
                    act_d      = pend_q;
                    pend_vld_d = 1'b0;
                    cnt_d      = RELOAD;
                    state_d    = START;
                    if (mem.request_enable) ovf_d = 1'b1;
                end else if (mem.request_enable) begin
                    // A request arriving in the response cycle enters service directly.
                    // Its timing is the same as for a request that enters the pending slot first.
                    act_d   = in_req;
                    cnt_d   = RELOAD;
                    state_d = START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            act_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovf_q      <= 1'b0;
            data_q     <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovf_q      <= ovf_d;
            data_q     <= data_d;
        end
    end

    // RAM contents survive reset. A write that coincides with reset is suppressed.
    always_ff @(posedge clk) begin
        if (we && rstn) begin
            for (int b = 0; b < 4; b++) begin
                if (act_q.wstrb[b]) ram_q[idx][8*b +: 8] <= act_q.wdata[8*b +: 8];
            end
        end
    end

    assign mem.response_enable = resp;
    assign mem.data            = data_d;
    assign mem.busy            = (state_q != S_IDLE) || pend_vld_q;
    assign mem.err_range       = resp && !in_range;
    assign mem.err_overflow    = ovf_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder. Instance A uses the default geometry.
// Instance B uses a 16-word RAM at 0x1000 to exercise the range checks.
module tb_mem_responder;
    localparam bit RD = 1'b0;
    localparam bit WR = 1'b1;

    logic clk = 1'b0;
    logic rstn;
    int   vec    = 0;
    int   miscmp = 0;

    always #5 clk = ~clk;

    mem_responder_if bus_a ();
    mem_responder_if bus_b ();

    mem_responder #(.DEPTH_LOG2(14), .LATENCY(2), .BASE_ADDR(32'h0)) u_a (
        .clk (clk), .rstn (rstn), .mem (bus_a)
    );
    mem_responder #(.DEPTH_LOG2(4), .LATENCY(2), .BASE_ADDR(32'h1000)) u_b (
        .clk (clk), .rstn (rstn), .mem (bus_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv(input bit u, input bit rq, input bit m, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
        if (!u) begin
            bus_a.request_enable = rq; bus_a.mode = m; bus_a.addr = a; bus_a.wdata = d; bus_a.wstrb = s;
        end else begin
            bus_b.request_enable = rq; bus_b.mode = m; bus_b.addr = a; bus_b.wdata = d; bus_b.wstrb = s;
        end
    endtask

    function automatic logic resp_of(input bit u);
        return u ? bus_b.response_enable : bus_a.response_enable;
    endfunction
    function automatic logic [31:0] data_of(input bit u);
        return u ? bus_b.data : bus_a.data;
    endfunction
    function automatic logic busy_of(input bit u);
        return u ? bus_b.busy : bus_a.busy;
    endfunction
    function automatic logic erng_of(input bit u);
        return u ? bus_b.err_range : bus_a.err_range;
    endfunction

    // One isolated request: there is no response one cycle after issue, the response comes after two cycles, and the bus is idle after that.
    task automatic txn(input string tag, input bit u, input bit m, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] exp_data, input logic exp_err);
        drv(u, 1'b1, m, a, d, s);
        tick();
        drv(u, 1'b0, RD, 32'd0, 32'd0, 4'd0);
        chk({tag, ".resp_early"}, 32'(resp_of(u)), 32'd0);
        chk({tag, ".busy"}, 32'(busy_of(u)), 32'd1);
        tick();
        chk({tag, ".resp"}, 32'(resp_of(u)), 32'd1);
        chk({tag, ".data"}, data_of(u), exp_data);
        chk({tag, ".err_range"}, 32'(erng_of(u)), 32'(exp_err));
        tick();
        chk({tag, ".resp_after"}, 32'(resp_of(u)), 32'd0);
        chk({tag, ".idle"}, 32'(busy_of(u)), 32'd0);
    endtask

    initial begin
        drv(1'b0, 1'b0, RD, 32'd0, 32'd0, 4'd0);
        drv(1'b1, 1'b0, RD, 32'd0, 32'd0, 4'd0);
        rstn = 1'b0;
        tick();
        tick();
        chk("rst.resp", 32'(bus_a.response_enable), 32'd0);
        chk("rst.data", bus_a.data, 32'd0);
        chk("rst.busy", 32'(bus_a.busy), 32'd0);
        chk("rst.err_range", 32'(bus_a.err_range), 32'd0);
        chk("rst.err_overflow", 32'(bus_a.err_overflow), 32'd0);
        rstn = 1'b1;
        tick();

        txn("wr10", 1'b0, WR, 32'h10, 32'hDEADBEEF, 4'b1111, 32'd0, 1'b0);
        txn("rd10", 1'b0, RD, 32'h10, 32'd0, 4'd0, 32'hDEADBEEF, 1'b0);
        txn("wr10.b2", 1'b0, WR, 32'h12, 32'h00AA0000, 4'b0100, 32'd0, 1'b0);
        txn("rd10.b2", 1'b0, RD, 32'h10, 32'd0, 4'd0, 32'hDEAABEEF, 1'b0);
        txn("wr10.b0", 1'b0, WR, 32'h10, 32'h00000011, 4'b0001, 32'd0, 1'b0);
        txn("rd10.b0", 1'b0, RD, 32'h10, 32'd0, 4'd0, 32'hDEAABE11, 1'b0);
        txn("wr10.s0", 1'b0, WR, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0);
        txn("wr20", 1'b0, WR, 32'h20, 32'h12345678, 4'b1111, 32'd0, 1'b0);

        // Two back-to-back reads: the second one waits in the pending slot.
        drv(1'b0, 1'b1, RD, 32'h10, 32'd0, 4'd0);
        tick();
        drv(1'b0, 1'b1, RD, 32'h20, 32'd0, 4'd0);
        chk("b2b.busy1", 32'(bus_a.busy), 32'd1);
        tick();
        drv(1'b0, 1'b0, RD, 32'd0, 32'd0, 4'd0);
        chk("b2b.resp1", 32'(bus_a.response_enable), 32'd1);
        chk("b2b.data1", bus_a.data, 32'hDEAABE11);
        tick();
        chk("b2b.gap", 32'(bus_a.response_enable), 32'd0);
        chk("b2b.busy3", 32'(bus_a.busy), 32'd1);
        tick();
        chk("b2b.resp2", 32'(bus_a.response_enable), 32'd1);
        chk("b2b.data2", bus_a.data, 32'h12345678);
        chk("b2b.busy4", 32'(bus_a.busy), 32'd1);
        tick();
        chk("b2b.idle", 32'(bus_a.busy), 32'd0);
        chk("b2b.ovf", 32'(bus_a.err_overflow), 32'd0);

        // Three consecutive requests: the third request is a write and must be dropped.
        drv(1'b0, 1'b1, RD, 32'h10, 32'd0, 4'd0);
        tick();
        drv(1'b0, 1'b1, RD, 32'h20, 32'd0, 4'd0);
        tick();
        drv(1'b0, 1'b1, WR, 32'h10, 32'hFFFFFFFF, 4'b1111);
        chk("ovf.resp1", 32'(bus_a.response_enable), 32'd1);
        chk("ovf.data1", bus_a.data, 32'hDEAABE11);
        chk("ovf.flag_early", 32'(bus_a.err_overflow), 32'd0);
        tick();
        drv(1'b0, 1'b0, RD, 32'd0, 32'd0, 4'd0);
        chk("ovf.flag", 32'(bus_a.err_overflow), 32'd1);
        chk("ovf.gap", 32'(bus_a.response_enable), 32'd0);
        tick();
        chk("ovf.resp2", 32'(bus_a.response_enable), 32'd1);
        chk("ovf.data2", bus_a.data, 32'h12345678);
        tick();
        chk("ovf.no_resp3", 32'(bus_a.response_enable), 32'd0);
        chk("ovf.idle", 32'(bus_a.busy), 32'd0);
        tick();
        chk("ovf.no_resp3b", 32'(bus_a.response_enable), 32'd0);
        chk("ovf.sticky", 32'(bus_a.err_overflow), 32'd1);
        txn("rd10.dropped", 1'b0, RD, 32'h10, 32'd0, 4'd0, 32'hDEAABE11, 1'b0);

        // Reset asserted in the cycle before the write's response: the write is lost.
        drv(1'b0, 1'b1, WR, 32'h10, 32'hCAFEF00D, 4'b1111);
        tick();
        drv(1'b0, 1'b0, RD, 32'd0, 32'd0, 4'd0);
        rstn = 1'b0;
        tick();
        chk("rstmid.resp", 32'(bus_a.response_enable), 32'd0);
        chk("rstmid.busy", 32'(bus_a.busy), 32'd0);
        chk("rstmid.ovf", 32'(bus_a.err_overflow), 32'd0);
        chk("rstmid.data", bus_a.data, 32'd0);
        rstn = 1'b1;
        tick();
        chk("rstmid.resp2", 32'(bus_a.response_enable), 32'd0);
        txn("rd10.post_rst", 1'b0, RD, 32'h10, 32'd0, 4'd0, 32'hDEAABE11, 1'b0);

        // Range checks on the small instance: its RAM covers 0x1000..0x103F.
        txn("b.wr1000", 1'b1, WR, 32'h1000, 32'h11112222, 4'b1111, 32'd0, 1'b0);
        txn("b.wr103c", 1'b1, WR, 32'h103C, 32'h0BADCAFE, 4'b1111, 32'd0, 1'b0);
        txn("b.rd1040", 1'b1, RD, 32'h1040, 32'd0, 4'd0, 32'd0, 1'b1);
        txn("b.wr0ffc", 1'b1, WR, 32'h0FFC, 32'hFFFFFFFF, 4'b1111, 32'd0, 1'b1);
        txn("b.rd103c", 1'b1, RD, 32'h103C, 32'd0, 4'd0, 32'h0BADCAFE, 1'b0);
        txn("b.rd1000", 1'b1, RD, 32'h1003, 32'd0, 4'd0, 32'h11112222, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
